// File: rtl/sdes_pkg.sv
// S-DES definitions shared by the encrypt and decrypt datapaths: widths, tables, FSM states.
// Tables list source bit positions (1-based from the MSB) in output-bit order.
package sdes_pkg;
    localparam int KEY_W = 10;
    localparam int BLK_W = 8;

    typedef enum logic [2:0] {IDLE, KEYGEN, ROUND1, ROUND2, DONE} sdes_state_t;

    localparam int P10_T   [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T    [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int IP_T    [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int IPINV_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int EP_T    [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int P4_T    [4]  = '{2, 4, 3, 1};

    localparam logic [1:0] S0_T [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2},
                                           '{2'd3, 2'd2, 2'd1, 2'd0},
                                           '{2'd0, 2'd2, 2'd1, 2'd3},
                                           '{2'd3, 2'd1, 2'd3, 2'd2}};
    localparam logic [1:0] S1_T [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                                           '{2'd2, 2'd0, 2'd1, 2'd3},
                                           '{2'd3, 2'd0, 2'd1, 2'd0},
                                           '{2'd2, 2'd1, 2'd0, 2'd3}};

    function automatic logic [KEY_W-1:0] perm_p10(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_W; i++) r[KEY_W-1-i] = k[KEY_W-P10_T[i]];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] perm_p8(input logic [KEY_W-1:0] k);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLK_W; i++) r[BLK_W-1-i] = k[KEY_W-P8_T[i]];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] perm_ip(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLK_W; i++) r[BLK_W-1-i] = d[BLK_W-IP_T[i]];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] perm_ipinv(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLK_W; i++) r[BLK_W-1-i] = d[BLK_W-IPINV_T[i]];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] perm_ep(input logic [3:0] d);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLK_W; i++) r[BLK_W-1-i] = d[4-EP_T[i]];
        return r;
    endfunction

    function automatic logic [3:0] perm_p4(input logic [3:0] d);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[3-i] = d[4-P4_T[i]];
        return r;
    endfunction

    function automatic logic [4:0] ls1(input logic [4:0] x);
        return {x[3:0], x[4]};
    endfunction

    // Returns {K1, K2}; K2 uses the halves rotated a further two places (LS-2).
    function automatic logic [2*BLK_W-1:0] gen_subkeys(input logic [KEY_W-1:0] key);
        logic [KEY_W-1:0] p, s1, s2;
        p  = perm_p10(key);
        s1 = {ls1(p[9:5]), ls1(p[4:0])};
        s2 = {ls1(ls1(s1[9:5])), ls1(ls1(s1[4:0]))};
        return {perm_p8(s1), perm_p8(s2)};
    endfunction
endpackage

// File: rtl/sdes_fk.sv
// S-DES round function fk: left nibble XORed with P4(S-boxes(E/P(right) ^ subkey)).
// Purely combinational; right nibble passes through unchanged.
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [BLK_W-1:0] data_i,
    input  logic [BLK_W-1:0] subkey_i,
    output logic [BLK_W-1:0] data_o
);
    logic [BLK_W-1:0] t;
    logic [1:0]       s0, s1;

    always_comb begin
        t  = perm_ep(data_i[3:0]) ^ subkey_i;
        // Row from the outer bits, column from the inner pair of each nibble.
        s0 = S0_T[{t[7], t[4]}][{t[6], t[5]}];
        s1 = S1_T[{t[3], t[0]}][{t[2], t[1]}];
        data_o = {data_i[7:4] ^ perm_p4({s0, s1}), data_i[3:0]};
    end
endmodule

// File: rtl/simple_des_decrypt.sv
// Multi-cycle S-DES engine (DIRECTION=1 decrypt, 0 encrypt); out_valid 4 edges after accept.
// One job at a time: in_ready only in IDLE, result held in DONE until out_ready.
module simple_des_decrypt
    import sdes_pkg::*;
#(
    parameter bit DIRECTION = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] ciphertext,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] plaintext,
    output logic             busy
);
    sdes_state_t      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [BLK_W-1:0] k1_q, k1_d, k2_q, k2_d;
    logic [BLK_W-1:0] pt_q, pt_d;
    logic [BLK_W-1:0] first_key, second_key;
    logic [BLK_W-1:0] fk_in, fk_key, fk_out;

    assign first_key  = DIRECTION ? k2_q : k1_q;
    assign second_key = DIRECTION ? k1_q : k2_q;
    // data_q holds the ciphertext until ROUND1, then the swapped half-round result.
    assign fk_in      = (state_q == ROUND1) ? perm_ip(data_q) : data_q;
    assign fk_key     = (state_q == ROUND1) ? first_key : second_key;

    sdes_fk u_fk (
        .data_i   (fk_in),
        .subkey_i (fk_key),
        .data_o   (fk_out)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        data_d  = data_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        pt_d    = pt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    key_d   = key;
                    data_d  = ciphertext;
                    state_d = KEYGEN;
                end
            end
            KEYGEN: begin
                {k1_d, k2_d} = gen_subkeys(key_q);
                state_d      = ROUND1;
            end
            ROUND1: begin
                data_d  = {fk_out[3:0], fk_out[7:4]};
                state_d = ROUND2;
            end
            ROUND2: begin
                pt_d    = perm_ipinv(fk_out);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            data_q  <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            data_q  <= data_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            pt_q    <= pt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign plaintext = pt_q;
endmodule

// File: tb/tb_simple_des_decrypt.sv
// Directed bench for simple_des_decrypt: decrypt and encrypt instances share stimulus and are
// compared every cycle against an integer-arithmetic S-DES model with a latency-phase tracker.
module tb_simple_des_decrypt;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] ciphertext = 8'h00;
    logic [9:0] key = 10'h000;
    logic       out_ready = 1'b1;

    logic       d_in_ready, d_out_valid, d_busy;
    logic [7:0] d_pt;
    logic       e_in_ready, e_out_valid, e_busy;
    logic [7:0] e_pt;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    localparam logic [9:0] KREF = 10'b1010000010;

    always #5 clk = ~clk;

    simple_des_decrypt #(.DIRECTION(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready),
        .ciphertext(ciphertext), .key(key), .out_valid(d_out_valid),
        .out_ready(out_ready), .plaintext(d_pt), .busy(d_busy)
    );

    simple_des_decrypt #(.DIRECTION(1'b0)) dut_enc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
        .ciphertext(ciphertext), .key(key), .out_valid(e_out_valid),
        .out_ready(out_ready), .plaintext(e_pt), .busy(e_busy)
    );

    // ---------------- reference model (integer arithmetic, tables as nibble strings) ----------------
    localparam logic [39:0] P10_M = 40'h35274A1986;
    localparam logic [39:0] P8_M  = 40'h637485A9;
    localparam logic [39:0] IP_M  = 40'h26314857;
    localparam logic [39:0] IPI_M = 40'h41357286;
    localparam logic [39:0] EP_M  = 40'h41232341;
    localparam logic [39:0] P4_M  = 40'h2431;
    int S0_M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1_M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    function automatic int perm(input int x, input int n_in, input int n_out, input logic [39:0] tbl);
        int r = 0;
        for (int j = 0; j < n_out; j++)
            r = (r << 1) | ((x >> (n_in - int'(tbl[4*(n_out-1-j) +: 4]))) & 1);
        return r;
    endfunction

    function automatic int rot5(input int x, input int n);
        int y = x;
        repeat (n) y = ((y << 1) | (y >> 4)) & 31;
        return y;
    endfunction

    function automatic void m_keys(input int k, output int k1, output int k2);
        int p = perm(k, 10, 10, P10_M);
        k1 = perm((rot5(p >> 5, 1) << 5) | rot5(p & 31, 1), 10, 8, P8_M);
        k2 = perm((rot5(p >> 5, 3) << 5) | rot5(p & 31, 3), 10, 8, P8_M);
    endfunction

    function automatic int m_fk(input int d, input int sk);
        int l = d >> 4;
        int r = d & 15;
        int t = perm(r, 4, 8, EP_M) ^ sk;
        int a = t >> 4;
        int b = t & 15;
        int s = (S0_M[((a >> 2) & 2) | (a & 1)][(a >> 1) & 3] << 2)
              |  S1_M[((b >> 2) & 2) | (b & 1)][(b >> 1) & 3];
        return ((l ^ perm(s, 4, 4, P4_M)) << 4) | r;
    endfunction

    function automatic int m_sdes(input int blk, input int k, input int decrypt);
        int k1, k2, ka, kb, x;
        m_keys(k, k1, k2);
        ka = decrypt ? k2 : k1;
        kb = decrypt ? k1 : k2;
        x = perm(blk, 8, 8, IP_M);
        x = m_fk(x, ka);
        x = ((x & 15) << 4) | (x >> 4);
        x = m_fk(x, kb);
        return perm(x, 8, 8, IPI_M);
    endfunction

    // Phase: 0 idle, 1..3 working, 4 result presented.
    int phase = 0;
    int acc_ct = 0, acc_key = 0;
    logic [7:0] exp_dec = 8'h00, exp_enc = 8'h00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase   = 0;
            exp_dec = 8'h00;
            exp_enc = 8'h00;
        end else if (phase == 0) begin
            if (in_valid) begin
                acc_ct  = int'(ciphertext);
                acc_key = int'(key);
                phase   = 1;
            end
        end else if (phase < 3) begin
            phase = phase + 1;
        end else if (phase == 3) begin
            phase   = 4;
            exp_dec = 8'(m_sdes(acc_ct, acc_key, 1));
            exp_enc = 8'(m_sdes(acc_ct, acc_key, 0));
        end else if (out_ready) begin
            phase = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            check("dec in_ready",  32'(d_in_ready),  32'(phase == 0));
            check("dec busy",      32'(d_busy),      32'(phase != 0));
            check("dec out_valid", 32'(d_out_valid), 32'(phase == 4));
            check("dec plaintext", 32'(d_pt),        32'(exp_dec));
            check("enc in_ready",  32'(e_in_ready),  32'(phase == 0));
            check("enc out_valid", 32'(e_out_valid), 32'(phase == 4));
            check("enc plaintext", 32'(e_pt),        32'(exp_enc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(output int lat);
        lat = 1;
        while (!d_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!d_out_valid) check("out_valid timeout", 32'(d_out_valid), 32'd1);
    endtask

    // Called at a negedge; returns at the first negedge with out_valid visible.
    task automatic run_job(input logic [7:0] ct, input logic [9:0] k, input bit corrupt, output int lat);
        in_valid   = 1'b1;
        ciphertext = ct;
        key        = k;
        @(negedge clk);
        in_valid = 1'b0;
        if (corrupt) begin
            ciphertext = ~ct;
            key        = ~k;
        end
        wait_done(lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, k1, k2, n_acc;
        logic [7:0] held, tmp;
        logic [7:0] exp_q[$];

        m_keys(int'(KREF), k1, k2);
        check("model K1", 32'(k1), 32'h0A4);
        check("model K2", 32'(k2), 32'h043);
        check("model decrypt 38", 32'(m_sdes(32'h38, int'(KREF), 1)), 32'h97);
        check("model encrypt 97", 32'(m_sdes(32'h97, int'(KREF), 0)), 32'h38);
        for (int i = 0; i < 3; i++) begin
            int ct = (i * 83 + 5) & 255;
            int kk = (i * 311 + 77) & 1023;
            check("model roundtrip", 32'(m_sdes(m_sdes(ct, kk, 0), kk, 1)), 32'(ct));
        end

        repeat (3) @(negedge clk);
        run_cmp = 1'b1;
        check("reset plaintext", 32'(d_pt), 32'h0);
        check("reset busy", 32'(d_busy), 32'h0);
        check("reset in_ready", 32'(d_in_ready), 32'h1);
        reset = 1'b1;
        @(negedge clk);

        // Reference vector in both directions.
        out_ready = 1'b1;
        run_job(8'h38, KREF, 1'b0, lat);
        check("latency decrypt", 32'(lat), 32'd4);
        check("decrypt 38 -> 97", 32'(d_pt), 32'h97);
        @(negedge clk);
        check("back to idle", 32'(d_in_ready), 32'h1);
        run_job(8'h97, KREF, 1'b0, lat);
        check("encrypt 97 -> 38", 32'(e_pt), 32'h38);
        @(negedge clk);

        // Consumer stall in DONE.
        out_ready = 1'b0;
        run_job(8'h5A, 10'h2F3, 1'b0, lat);
        held = d_pt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall out_valid", 32'(d_out_valid), 32'h1);
            check("stall in_ready", 32'(d_in_ready), 32'h0);
            check("stall plaintext", 32'(d_pt), 32'(held));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall release", 32'(d_in_ready), 32'h1);

        // Back-to-back stream with in_valid held high.
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (d_out_valid) begin
                tmp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                check("stream order", 32'(d_pt), 32'(tmp));
            end
            in_valid   = 1'b1;
            ciphertext = 8'(i * 37 + 11);
            key        = 10'(i * 101 + 3);
            if (d_in_ready) begin
                n_acc++;
                exp_q.push_back(8'(m_sdes(int'(ciphertext), int'(key), 1)));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream accepts", 32'(n_acc), 32'd4);
        check("stream drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // Inputs change right after acceptance.
        run_job(8'h38, KREF, 1'b1, lat);
        check("inputs captured at accept", 32'(d_pt), 32'h97);
        @(negedge clk);

        // Asynchronous reset during ROUND1.
        in_valid   = 1'b1;
        ciphertext = 8'h97;
        key        = KREF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("in ROUND1 before reset", 32'(phase), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("async rst out_valid", 32'(d_out_valid), 32'h0);
        check("async rst busy", 32'(d_busy), 32'h0);
        check("async rst plaintext", 32'(d_pt), 32'h0);
        check("async rst enc plaintext", 32'(e_pt), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post reset in_ready", 32'(d_in_ready), 32'h1);
        run_job(8'h38, KREF, 1'b0, lat);
        check("post reset latency", 32'(lat), 32'd4);
        check("post reset result", 32'(d_pt), 32'h97);
        repeat (3) @(negedge clk);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simple_des_decrypt.md
SIMPLE_DES_DECRYPT -- requirements
Module: simple_des_decrypt

Interface
REQ-001 The block SHALL have one parameter: DIRECTION, default 1, where 1 = decrypt (subkeys applied K2 then K1) and 0 = encrypt (K1 then K2).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  ciphertext and key present.
REQ-005 Port: in_ready  output  1  block can accept a job.
REQ-006 Port: ciphertext  input  8  data to decrypt.
REQ-007 Port: key  input  10  S-DES key, bit 9 = MSB of P10 input.
REQ-008 Port: out_valid  output  1  plaintext valid.
REQ-009 Port: out_ready  input  1  consumer accepts plaintext.
REQ-010 Port: plaintext  output  8  result.
REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL implement standard S-DES (P10, LS-1, LS-2, P8, IP, E/P, S0, S1, P4, SW, IP^-1) with DIRECTION selecting subkey order.
REQ-013 The FSM SHALL have states IDLE, KEYGEN, ROUND1, ROUND2 and DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, ciphertext and key SHALL be registered and the state SHALL go to KEYGEN.
REQ-015 KEYGEN: K1 and K2 SHALL be computed from the registered key into 8-bit registers; the state SHALL then go to ROUND1.
REQ-016 ROUND1: IP, then fk with the first subkey, then SW; the 8-bit result SHALL be registered; the state SHALL then go to ROUND2.
REQ-017 ROUND2: fk with the second subkey, then IP^-1; the result SHALL be registered into plaintext; the state SHALL then go to DONE.
REQ-018 DONE: out_valid=1 and plaintext SHALL be held stable until out_ready=1; on that edge the state SHALL go to IDLE.
REQ-019 Latency SHALL be fixed: out_valid rises 4 edges after the accepting edge (KEYGEN, ROUND1, ROUND2, DONE); max throughput SHALL be 1 job per 5 cycles.
REQ-020 in_ready SHALL be 0 in every non-IDLE state, including DONE with out_ready=1; there is no overlap of jobs.
REQ-021 Input changes after acceptance SHALL NOT affect the job in flight.
REQ-022 in_valid in a non-IDLE state SHALL be ignored; it is not queued.
REQ-023 out_ready while not in DONE SHALL be ignored.
REQ-024 plaintext SHALL keep its last value after the handoff until the next ROUND2 write.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE and set out_valid=0, plaintext=0, all key/data registers=0 and busy=0; in_ready=1 while in IDLE.
REQ-026 Reset mid-job SHALL abandon the job with no out_valid pulse; the first accept after reset release SHALL behave as from power-up.

Structure
REQ-027 Shared package sdes_pkg SHALL hold: the permutation tables (P10, P8, IP, IP^-1, E/P, P4) as constants, the S0/S1 4x4 tables, state enum sdes_state_t, and widths KEY_W=10 and BLK_W=8; the package SHALL be shared with the encrypt path.
REQ-028 There SHALL be one sub-module, sdes_fk, a combinational round function (8-bit data, 8-bit subkey -> 8-bit), instantiated once and muxed between ROUND1 and ROUND2.

Verification
REQ-029 Reset, then key=10'b1010000010, ciphertext=8'h38, out_ready=1 -> out_valid 4 edges after accept, plaintext=8'h97, then IDLE.
REQ-030 DIRECTION=0, key=10'b1010000010, input 8'h97 -> output 8'h38.
REQ-031 Hold out_ready=0 for 6 cycles in DONE -> out_valid=1, plaintext constant, in_ready=0 throughout; accepted on the edge with out_ready=1.
REQ-032 Hold in_valid=1 with new data continuously -> jobs accepted every 5th cycle; results match the model in order.
REQ-033 Assert reset=0 during ROUND1 -> asynchronously out_valid=0, busy=0, plaintext=0; after release, in_ready=1 and the next job gives the correct result.
REQ-034 Change ciphertext/key during KEYGEN -> result equals the value computed from the inputs at the accept edge.
